// File: rtl/div16by8_seq.sv
// div16by8_seq
// Sequential restoring divider: 16-bit unsigned dividend by 8-bit unsigned
// divisor, one quotient bit per clock, with valid/ready handshakes on the
// request and result sides.
//
// Optional build macro:
//   DIV_ZERO_FAST_EN - a zero divisor skips the iteration loop and presents
//                      the fixed divide-by-zero result one cycle after
//                      acceptance instead of after sixteen.
//
// A zero divisor always yields quotient=16'hFFFF, remainder=8'hFF,
// div_zero=1, regardless of what the iteration loop computed.

module div16by8_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    // Quotient shift register: starts holding the dividend, whose bits are
    // shifted out of the top into the partial remainder while quotient bits
    // are shifted in at the bottom.
    logic [15:0] r_quotShift;
    // Partial remainder needs nine bits: after the shift it can reach
    // 2*divisor-1, which exceeds eight bits for divisors above 128.
    logic [8:0]  r_partRem;
    logic [7:0]  r_divisor;
    logic [3:0]  r_count;
    logic        r_divZero;

    logic        w_accept;
    logic        w_release;
    logic        w_lastIter;
    logic        w_skipLoop;
    logic [8:0]  w_prShift;
    logic [8:0]  w_prSub;
    logic        w_prGe;

    // Handshake qualifiers and loop-termination conditions
    always_comb begin
        w_accept   = in_valid && (r_state == IDLE);
        w_release  = out_ready && (r_state == DONE);
        w_lastIter = (r_count == 4'd15);
`ifdef DIV_ZERO_FAST_EN
        w_skipLoop = r_divZero;
`else
        w_skipLoop = 1'b0;
`endif
    end

    // One restoring-division step: shift, trial subtract, keep if non-negative
    always_comb begin
        w_prShift = {r_partRem[7:0], r_quotShift[15]};
        w_prGe    = (w_prShift >= {1'b0, r_divisor});
        w_prSub   = w_prShift - {1'b0, r_divisor};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; a zero divisor in the fast build leaves BUSY after
    // one cycle so the result still appears one edge after acceptance
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = BUSY;
                end
            end
            BUSY: begin
                if (w_lastIter || w_skipLoop) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (w_release) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath: load operands on acceptance, iterate one bit per BUSY cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quotShift <= 16'd0;
            r_partRem   <= 9'd0;
            r_divisor   <= 8'd0;
            r_count     <= 4'd0;
            r_divZero   <= 1'b0;
        end else if (w_accept) begin
            r_quotShift <= dividend;
            r_partRem   <= 9'd0;
            r_divisor   <= divisor;
            r_count     <= 4'd0;
            r_divZero   <= (divisor == 8'd0);
        end else if (r_state == BUSY) begin
            r_quotShift <= {r_quotShift[14:0], w_prGe};
            r_partRem   <= w_prGe ? w_prSub : w_prShift;
            r_count     <= r_count + 4'd1;
        end
    end

    // Outputs; result fields are zero outside DONE and forced on divide-by-zero
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        quotient  = 16'd0;
        remainder = 8'd0;
        div_zero  = 1'b0;
        if (r_state == DONE) begin
            div_zero = r_divZero;
            if (r_divZero) begin
                quotient  = 16'hFFFF;
                remainder = 8'hFF;
            end else begin
                quotient  = r_quotShift;
                remainder = r_partRem[7:0];
            end
        end
    end

endmodule

// File: tb/tb_div16by8_seq.sv
// tb_div16by8_seq
// Directed vector table plus hand-written sequences for backpressure,
// mid-operation reset, and a randomised producer/consumer run with an
// ordering scoreboard. Honours DIV_ZERO_FAST_EN for the zero-divisor latency.

module tb_div16by8_seq;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
    } vec_t;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 16;
`endif
    localparam int NUM_VECS = 10;
    localparam int NUM_RAND = 150;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;

    int checks   = 0;
    int failures = 0;

    vec_t vecs [NUM_VECS];
    vec_t expQueue [$];

    div16by8_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Issue one request and wait for out_valid; latency counts edges after accept
    task automatic applyStimulus(input logic [15:0] a, input logic [7:0] b,
                                 output int latency, output bit ok);
        int guard;
        ok      = 1'b1;
        latency = 0;
        guard   = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            ok = 1'b0;
        end else begin
            dividend = a;
            divisor  = b;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            do begin
                @(posedge clk);
                #1;
                latency++;
            end while (!out_valid && latency < 100);
            if (!out_valid) ok = 1'b0;
        end
    endtask

    // Accept the current result and confirm the divider is ready next cycle
    task automatic releaseResult(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_post_in_ready"}, {31'd0, in_ready}, 32'd1);
        checkOutput({tag, "_post_out_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    // Producer for the random run: holds in_valid until accepted
    task automatic randProducer();
        int   guard;
        vec_t v;
        for (int i = 0; i < NUM_RAND; i++) begin
            @(negedge clk);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            v.a = 16'($urandom_range(0, 65535));
            v.b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            if (v.b == 8'd0) begin
                v.q  = 16'hFFFF;
                v.r  = 8'hFF;
                v.dz = 1'b1;
            end else begin
                v.q  = v.a / {8'd0, v.b};
                v.r  = 8'(v.a % {8'd0, v.b});
                v.dz = 1'b0;
            end
            dividend = v.a;
            divisor  = v.b;
            in_valid = 1'b1;
            guard    = 0;
            while (!in_ready && guard < 300) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) begin
                checkOutput("rand_accept_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                break;
            end
            expQueue.push_back(v);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    // Consumer for the random run: random out_ready, in-order scoreboard
    task automatic randConsumer();
        int   received;
        int   cyc;
        vec_t e;
        received = 0;
        cyc      = 0;
        while (received < NUM_RAND && cyc < NUM_RAND * 80) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                if (expQueue.size() == 0) begin
                    checkOutput("rand_unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = expQueue.pop_front();
                    checkOutput("rand_quotient", {16'd0, quotient}, {16'd0, e.q});
                    checkOutput("rand_remainder", {24'd0, remainder}, {24'd0, e.r});
                    checkOutput("rand_div_zero", {31'd0, div_zero}, {31'd0, e.dz});
                end
                received++;
            end
        end
        out_ready = 1'b0;
        checkOutput("rand_received", received, NUM_RAND);
    endtask

    initial begin
        int   lat;
        bit   ok;
        bit   sawValid;
        string tag;

        vecs[0] = '{16'h3039, 8'h7B, 16'h0064, 8'h2D, 1'b0};
        vecs[1] = '{16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0};
        vecs[2] = '{16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0};
        vecs[3] = '{16'h0000, 8'h05, 16'h0000, 8'h00, 1'b0};
        vecs[4] = '{16'h1234, 8'h00, 16'hFFFF, 8'hFF, 1'b1};
        vecs[5] = '{16'h00C8, 8'h0A, 16'h0014, 8'h00, 1'b0};
        vecs[6] = '{16'h0001, 8'hFF, 16'h0000, 8'h01, 1'b0};
        vecs[7] = '{16'hFFFE, 8'hFF, 16'h0100, 8'hFE, 1'b0};
        vecs[8] = '{16'h8000, 8'h80, 16'h0100, 8'h00, 1'b0};
        vecs[9] = '{16'h00FF, 8'h10, 16'h000F, 8'h0F, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 16'd0;
        divisor   = 8'd0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_quotient", {16'd0, quotient}, 32'd0);
        checkOutput("reset_remainder", {24'd0, remainder}, 32'd0);
        checkOutput("reset_div_zero", {31'd0, div_zero}, 32'd0);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < NUM_VECS; i++) begin
            tag = $sformatf("vec%0d", i);
            applyStimulus(vecs[i].a, vecs[i].b, lat, ok);
            checkOutput({tag, "_completed"}, {31'd0, ok}, 32'd1);
            checkOutput({tag, "_quotient"}, {16'd0, quotient}, {16'd0, vecs[i].q});
            checkOutput({tag, "_remainder"}, {24'd0, remainder}, {24'd0, vecs[i].r});
            checkOutput({tag, "_div_zero"}, {31'd0, div_zero}, {31'd0, vecs[i].dz});
            checkOutput({tag, "_latency"}, lat, (vecs[i].b == 8'd0) ? ZERO_LAT : 16);
            checkOutput({tag, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
            releaseResult(tag);
        end

        // Backpressure: result held stable for 10 cycles with out_ready low
        applyStimulus(16'h3039, 8'h7B, lat, ok);
        checkOutput("bp_completed", {31'd0, ok}, 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("bp_quotient", {16'd0, quotient}, 32'h0064);
            checkOutput("bp_remainder", {24'd0, remainder}, 32'h2D);
        end
        releaseResult("bp");

        // Reset pulsed in the middle of BUSY discards the in-flight result
        @(negedge clk);
        dividend = 16'hFFFF;
        divisor  = 8'h03;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n    = 1'b1;
        sawValid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("rst_discard_no_valid", {31'd0, sawValid}, 32'd0);
        checkOutput("rst_after_in_ready", {31'd0, in_ready}, 32'd1);
        applyStimulus(16'h00C8, 8'h0A, lat, ok);
        checkOutput("rst_next_completed", {31'd0, ok}, 32'd1);
        checkOutput("rst_next_quotient", {16'd0, quotient}, 32'h0014);
        checkOutput("rst_next_remainder", {24'd0, remainder}, 32'h00);
        checkOutput("rst_next_latency", lat, 16);
        releaseResult("rst_next");

        // Random producer/consumer run with held in_valid and result stalls
        fork
            randProducer();
            randConsumer();
        join
        checkOutput("rand_queue_empty", expQueue.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
